vendor_ctrl: RTL
================

# vendor_ctrl

Transaction sequencer for the ticket vending datapath. It latches a destination and ticket count, then opens the coin gate and accumulates one- and ten-unit coins. On confirm it emits one pulse per ticket followed by one pulse per unit of change; on cancel or timeout it refunds everything inserted. It sits between the front-panel inputs and the price lookup, which stays external, and drives the ticket and coin-out actuators directly.

## Interface
- DW, 8, datapath width of dest, count and unit price
- MAX_COUNT, 4, largest accepted ticket count per transaction
- TIMEOUT, 1000, idle cycles in PAY before automatic refund
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- dest_in  in  DW  requested destination ID
- count_in  in  DW  requested ticket count
- select_valid  in  1  one-cycle strobe; dest_in/count_in valid
- unit_price  in  DW  per-ticket price for dest_out (combinational lookup)
- coin_one_in  in  1  one-cycle pulse, one-unit coin accepted
- coin_ten_in  in  1  one-cycle pulse, ten-unit coin accepted
- confirm  in  1  one-cycle strobe, buyer requests issue
- cancel  in  1  one-cycle strobe, buyer aborts
- dest_out  out  DW  latched destination, drives price lookup
- coin_gate_open  out  1  high only in PAY
- ticket_pulse  out  1  one pulse per issued ticket
- coin_one_out_pulse  out  1  one pulse per unit returned
- paid  out  2*DW  running inserted total
- short_err  out  1  one-cycle flag: confirm with insufficient funds
- done  out  1  one-cycle flag on return to IDLE after DISPENSE/REFUND

## Operation
- States: IDLE, PRICE, PAY, DISPENSE, CHANGE, REFUND.
- IDLE → PRICE on select_valid with 1 ≤ count_in ≤ MAX_COUNT. Latch dest and count. An invalid count is ignored and the block stays in IDLE.
- PRICE → PAY after one cycle. Compute price = unit_price × count in 2*DW bits, then clear paid and the timeout counter.
- PAY: each coin adds 1 or 10; both coins in one cycle add 11. paid saturates at all-ones. A coin clears the timeout counter.
- Priority in PAY: cancel > confirm > timeout.
  - A coin arriving in the same cycle as cancel or confirm is counted first.
  - confirm with paid ≥ price → DISPENSE, change = paid − price.
  - confirm with paid < price → short_err pulse; stay in PAY.
  - cancel, or the counter reaching TIMEOUT → REFUND, refund = paid.
- DISPENSE emits exactly count ticket pulses. Then CHANGE if change > 0, else IDLE.
- CHANGE emits change coin_one_out pulses, then IDLE.
- REFUND emits refund coin_one_out pulses, then IDLE. paid = 0 goes straight to IDLE.
- Change is always paid in one-unit coins.
- Inputs outside their owning state are ignored:
  - coins while the gate is closed;
  - select_valid outside IDLE;
  - confirm and cancel outside PAY.
- Asserting rst mid-transaction aborts it immediately. All state clears and no refund is issued.

## Timing
- Reset values:
  - state = IDLE
  - all pulse and flag outputs = 0
  - coin_gate_open = 0
  - paid = 0
  - dest_out = 0
- select_valid at edge t puts the block in PRICE at t+1 and PAY at t+2, so coin_gate_open rises at t+2.
- Pulse trains: high 1 cycle, low 1 cycle, period 2. N pulses occupy 2N cycles.
  - The first pulse is in the cycle after state entry.
  - The next state is entered after the final low cycle.
- done is asserted in the first IDLE cycle after a DISPENSE/CHANGE/REFUND sequence.
- short_err is asserted in the cycle after the rejected confirm.

## Structure
- Package vendor_pkg holds:
  - the state enum;
  - default DW, MAX_COUNT and TIMEOUT;
  - the coin value constants ONE=1 and TEN=10.
- One sub-module, pulse_train: loads an N-bit count on a start strobe, emits count pulses at period 2, and raises a finished flag.
- vendor_ctrl instantiates one pulse_train and muxes it onto the ticket or coin-out output by state.

## Test plan
- dest=16, count=2, unit_price=5. Insert ten then one, confirm → 2 ticket_pulse, then 1 coin_one_out_pulse, then done.
- count=1, price=7. Insert one ×3, confirm → short_err, stay in PAY. Insert ten, confirm → 1 ticket, 6 coin pulses.
- count=3, price=4. Insert ten, then cancel in the same cycle as a coin_one → 11 coin pulses, 0 tickets.
- Insert one coin, then idle for TIMEOUT cycles → REFUND with 1 coin pulse. Separately, count_in=0 and count_in=MAX_COUNT+1 → block stays in IDLE.
- Exact payment: count=2, price=10, insert two tens, confirm → 2 tickets, no CHANGE, done.
- Assert rst during DISPENSE after the first pulse → outputs drop asynchronously, IDLE, no further pulses.

Source files
------------

// File: rtl/vendor_pkg.sv
// vendor_pkg: shared state encoding, default sizing and coin values for the ticket vending sequencer.
package vendor_pkg;
    typedef enum logic [2:0] {IDLE, PRICE, PAY, DISPENSE, CHANGE, REFUND} state_t;
    localparam int DEF_DW        = 8;
    localparam int DEF_MAX_COUNT = 4;
    localparam int DEF_TIMEOUT   = 1000;
    localparam int ONE           = 1;
    localparam int TEN           = 10;
endpackage

// File: rtl/vendor_ctrl_pulse_train.sv
// pulse_train: loads a count on start and emits that many high/low pulses at period 2.
// finished is high during the final low cycle so a successor can be started on the same edge.
module pulse_train #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] count,
    output logic         pulse,
    output logic         finished
);
    logic [W-1:0] remaining;
    logic         phase;
    logic         busy;

    assign busy     = remaining != '0;
    assign pulse    = busy && !phase;
    assign finished = busy && phase && remaining == W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
            phase     <= 1'b0;
        end else if (start) begin
            remaining <= count;
            phase     <= 1'b0;
        end else if (busy) begin
            phase     <= !phase;
            remaining <= phase ? remaining - 1'b1 : remaining;
        end
    end
endmodule

// File: rtl/vendor_ctrl.sv
// vendor_ctrl: ticket vending sequencer -- select, price, coin collection, then ticket/change or refund
// pulse trains driven from a single shared pulse_train.
module vendor_ctrl
    import vendor_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int MAX_COUNT = DEF_MAX_COUNT,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   dest_in,
    input  logic [DW-1:0]   count_in,
    input  logic            select_valid,
    input  logic [DW-1:0]   unit_price,
    input  logic            coin_one_in,
    input  logic            coin_ten_in,
    input  logic            confirm,
    input  logic            cancel,
    output logic [DW-1:0]   dest_out,
    output logic            coin_gate_open,
    output logic            ticket_pulse,
    output logic            coin_one_out_pulse,
    output logic [2*DW-1:0] paid,
    output logic            short_err,
    output logic            done
);
    localparam int PW = 2 * DW;
    localparam int SW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state, state_nx;
    logic [DW-1:0] cnt;
    logic [PW-1:0] price, change, change_nx, paid_nx, pt_count;
    logic [SW-1:0] sum;
    logic [TW-1:0] tcnt;
    logic          coin, timeout, pt_start, pt_pulse, pt_fin, done_nx, short_nx;

    always_comb begin
        coin      = coin_one_in || coin_ten_in;
        sum       = {1'b0, paid} + (coin_one_in ? SW'(ONE) : '0) + (coin_ten_in ? SW'(TEN) : '0);
        paid_nx   = sum[PW] ? '1 : sum[PW-1:0];
        timeout   = !coin && tcnt == TW'(TIMEOUT - 1);
        state_nx  = state;
        pt_start  = 1'b0;
        pt_count  = paid_nx;
        change_nx = change;
        done_nx   = 1'b0;
        short_nx  = 1'b0;
        case (state)
            IDLE:
                if (select_valid && count_in != '0 && count_in <= DW'(MAX_COUNT)) state_nx = PRICE;
            PRICE:
                state_nx = PAY;
            PAY:
                // coins in the deciding cycle are already folded into paid_nx
                if (cancel || (!confirm && timeout)) begin
                    state_nx = paid_nx == '0 ? IDLE : REFUND;
                    pt_start = paid_nx != '0;
                    done_nx  = paid_nx == '0;
                end else if (confirm) begin
                    if (paid_nx >= price) begin
                        state_nx  = DISPENSE;
                        pt_start  = 1'b1;
                        pt_count  = PW'(cnt);
                        change_nx = paid_nx - price;
                    end else begin
                        short_nx = 1'b1;
                    end
                end
            DISPENSE:
                if (pt_fin) begin
                    state_nx = change != '0 ? CHANGE : IDLE;
                    pt_start = change != '0;
                    pt_count = change;
                    done_nx  = change == '0;
                end
            CHANGE, REFUND:
                if (pt_fin) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            default:
                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dest_out  <= '0;
            cnt       <= '0;
            price     <= '0;
            paid      <= '0;
            change    <= '0;
            tcnt      <= '0;
            done      <= 1'b0;
            short_err <= 1'b0;
        end else begin
            state     <= state_nx;
            change    <= change_nx;
            done      <= done_nx;
            short_err <= short_nx;
            if (state == IDLE && state_nx == PRICE) begin
                dest_out <= dest_in;
                cnt      <= count_in;
            end
            if (state == PRICE) begin
                price <= PW'(unit_price) * PW'(cnt);
                paid  <= '0;
                tcnt  <= '0;
            end
            if (state == PAY) begin
                paid <= paid_nx;
                tcnt <= coin ? '0 : (tcnt == TW'(TIMEOUT - 1) ? tcnt : tcnt + 1'b1);
            end
        end
    end

    pulse_train #(.W(PW)) u_pt (
        .clk      (clk),
        .rst      (rst),
        .start    (pt_start),
        .count    (pt_count),
        .pulse    (pt_pulse),
        .finished (pt_fin)
    );

    assign coin_gate_open     = state == PAY;
    assign ticket_pulse       = state == DISPENSE && pt_pulse;
    assign coin_one_out_pulse = (state == CHANGE || state == REFUND) && pt_pulse;
endmodule
